// File: rtl/onehot_stream_demux.sv
// One-hot routed valid/ready demux: each beat goes to the lowest set bit of in_sel_i,
// held in a 1-entry register slot per channel. Define ONEHOT_DEMUX_CHECK_EN to drop multi-bit selects and flag err_o.
module onehot_stream_demux #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [DATA_W-1:0]        in_data_i,
  input  logic [NUM_CH-1:0]        in_sel_i,
  output logic [NUM_CH-1:0]        out_valid_o,
  input  logic [NUM_CH-1:0]        out_ready_i,
  output logic [NUM_CH*DATA_W-1:0] out_data_o,
  output logic [CNT_W-1:0]         drop_cnt_o,
  output logic                     err_o,
  input  logic                     err_clr_i
);

  localparam logic [NUM_CH-1:0] SEL_ONE = NUM_CH'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

  logic [NUM_CH-1:0]             valid_q, valid_d;
  logic [NUM_CH-1:0][DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]              drop_cnt_q, drop_cnt_d;
  logic                          err_q, err_d;

  logic [NUM_CH-1:0] free;
  logic [NUM_CH-1:0] dest_oh;
  logic              drop_sel;
  logic              sel_err;
  logic              accept;
  logic              route;

  // Isolate the lowest set bit: x & -x.
  assign dest_oh = in_sel_i & (~in_sel_i + SEL_ONE);
  assign free    = ~valid_q | out_ready_i;

`ifdef ONEHOT_DEMUX_CHECK_EN
  assign sel_err = |(in_sel_i & (in_sel_i - SEL_ONE));
`else
  assign sel_err = 1'b0;
`endif

  assign drop_sel   = (in_sel_i == '0) | sel_err;
  assign in_ready_o = drop_sel | (|(dest_oh & free));
  assign accept     = in_valid_i & in_ready_o;
  assign route      = accept & ~drop_sel;

  always_comb begin
    valid_d    = valid_q;
    data_d     = data_q;
    drop_cnt_d = drop_cnt_q;
    err_d      = err_q;
    for (int k = 0; k < NUM_CH; k++) begin
      if (valid_q[k] && out_ready_i[k]) valid_d[k] = 1'b0;
      if (route && dest_oh[k]) begin
        valid_d[k] = 1'b1;
        data_d[k]  = in_data_i;
      end
    end
    if (accept && drop_sel && drop_cnt_q != CNT_MAX) drop_cnt_d = drop_cnt_q + CNT_ONE;
    if (accept && sel_err) err_d = 1'b1;
    // Clear wins over any same-cycle increment or error set.
    if (err_clr_i) begin
      drop_cnt_d = '0;
      err_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q    <= '0;
      data_q     <= '0;
      drop_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      data_q     <= data_d;
      drop_cnt_q <= drop_cnt_d;
      err_q      <= err_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign drop_cnt_o  = drop_cnt_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_onehot_stream_demux.sv
// Directed bench for onehot_stream_demux; expectations follow ONEHOT_DEMUX_CHECK_EN when defined.
module tb_onehot_stream_demux;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 8;

  logic                     clk = 1'b0;
  logic                     reset_n;
  logic                     in_valid_i;
  logic                     in_ready_o;
  logic [DATA_W-1:0]        in_data_i;
  logic [NUM_CH-1:0]        in_sel_i;
  logic [NUM_CH-1:0]        out_valid_o;
  logic [NUM_CH-1:0]        out_ready_i;
  logic [NUM_CH*DATA_W-1:0] out_data_o;
  logic [CNT_W-1:0]         drop_cnt_o;
  logic                     err_o;
  logic                     err_clr_i;

  int n_chk = 0;
  int n_err = 0;

  onehot_stream_demux #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .in_data_i  (in_data_i),
    .in_sel_i   (in_sel_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_data_o (out_data_o),
    .drop_cnt_o (drop_cnt_o),
    .err_o      (err_o),
    .err_clr_i  (err_clr_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] ch_data(input int k);
    return out_data_o[k*DATA_W +: DATA_W];
  endfunction

  // Advance one edge, then sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int any_valid;

  initial begin
    reset_n     = 1'b0;
    in_valid_i  = 1'b0;
    in_data_i   = '0;
    in_sel_i    = '0;
    out_ready_i = 4'b1111;
    err_clr_i   = 1'b0;
    #12;
    chk("rst_valid", 32'(out_valid_o), 32'h0);
    chk("rst_data",  32'(out_data_o),  32'h0);
    chk("rst_cnt",   32'(drop_cnt_o),  32'h0);
    chk("rst_err",   32'(err_o),       32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    step();

    // Single beat to ch2
    in_valid_i = 1'b1; in_sel_i = 4'b0100; in_data_i = 8'hA5;
    #1 chk("t1_ready", 32'(in_ready_o), 32'h1);
    step();
    in_valid_i = 1'b0; in_sel_i = 4'b0000;
    chk("t1_valid", 32'(out_valid_o), 32'h4);
    chk("t1_data",  32'(ch_data(2)),  32'hA5);
    step();
    chk("t1_gone",  32'(out_valid_o), 32'h0);

    // Back-to-back 1..8 on ch1
    for (int i = 1; i <= 8; i++) begin
      in_valid_i = 1'b1; in_sel_i = 4'b0010; in_data_i = 8'(i);
      #1 chk("t2_ready", 32'(in_ready_o), 32'h1);
      step();
      chk("t2_valid", 32'(out_valid_o), 32'h2);
      chk("t2_data",  32'(ch_data(1)),  32'(i));
    end
    in_valid_i = 1'b0; in_sel_i = 4'b0000;
    step();
    chk("t2_end", 32'(out_valid_o), 32'h0);

    // Stall on ch0, head beat switches to ch3
    out_ready_i = 4'b1110;
    in_valid_i = 1'b1; in_sel_i = 4'b0001; in_data_i = 8'h11;
    step();
    in_data_i = 8'h22;
    #1 chk("t3_blocked", 32'(in_ready_o), 32'h0);
    step();
    chk("t3_ch0_hold", 32'(ch_data(0)), 32'h11);
    in_sel_i = 4'b1000; in_data_i = 8'h33;
    #1 chk("t3_ready_ch3", 32'(in_ready_o), 32'h1);
    step();
    in_valid_i = 1'b0; in_sel_i = 4'b0000;
    chk("t3_valid", 32'(out_valid_o), 32'h9);
    chk("t3_ch3",   32'(ch_data(3)),  32'h33);
    chk("t3_ch0",   32'(ch_data(0)),  32'h11);
    out_ready_i = 4'b1111;
    step();
    chk("t3_drained", 32'(out_valid_o), 32'h0);
    chk("t3_ch0_kept", 32'(ch_data(0)), 32'h11);

    // 300 zero-select beats saturate the drop counter
    any_valid = 0;
    in_valid_i = 1'b1; in_sel_i = 4'b0000; in_data_i = 8'h77;
    #1 chk("t4_ready", 32'(in_ready_o), 32'h1);
    for (int i = 1; i <= 300; i++) begin
      step();
      if (out_valid_o != 0) any_valid++;
      if (i == 10)  chk("t4_cnt10",  32'(drop_cnt_o), 32'd10);
      if (i == 255) chk("t4_cnt255", 32'(drop_cnt_o), 32'd255);
    end
    chk("t4_novalid", 32'(any_valid), 32'h0);
    chk("t4_sat",     32'(drop_cnt_o), 32'd255);
    chk("t4_noerr",   32'(err_o),      32'h0);
    err_clr_i = 1'b1;
    step();
    err_clr_i = 1'b0; in_valid_i = 1'b0;
    chk("t4_clr", 32'(drop_cnt_o), 32'h0);

    // Multi-bit select
    in_valid_i = 1'b1; in_sel_i = 4'b0110; in_data_i = 8'h3C;
    #1 chk("t5_ready", 32'(in_ready_o), 32'h1);
    step();
    in_valid_i = 1'b0; in_sel_i = 4'b0000;
`ifdef ONEHOT_DEMUX_CHECK_EN
    chk("t5_valid", 32'(out_valid_o), 32'h0);
    chk("t5_err",   32'(err_o),       32'h1);
    chk("t5_cnt",   32'(drop_cnt_o),  32'h1);
    step();
    chk("t5_sticky", 32'(err_o), 32'h1);
`else
    chk("t5_valid", 32'(out_valid_o), 32'h2);
    chk("t5_data",  32'(ch_data(1)),  32'h3C);
    chk("t5_err",   32'(err_o),       32'h0);
    chk("t5_cnt",   32'(drop_cnt_o),  32'h0);
    step();
`endif
    err_clr_i = 1'b1;
    step();
    err_clr_i = 1'b0;
    chk("t5_clr_err", 32'(err_o),      32'h0);
    chk("t5_clr_cnt", 32'(drop_cnt_o), 32'h0);

    // Async reset mid-stream with ch2 holding a beat
    out_ready_i = 4'b1011;
    in_valid_i = 1'b1; in_sel_i = 4'b0100; in_data_i = 8'h5C;
    step();
    in_sel_i = 4'b0000;
    step();
    in_valid_i = 1'b0;
    chk("t6_pre_valid", 32'(out_valid_o), 32'h4);
    chk("t6_pre_cnt",   32'(drop_cnt_o),  32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(out_valid_o), 32'h0);
    chk("t6_rst_cnt",   32'(drop_cnt_o),  32'h0);
    chk("t6_rst_data",  32'(out_data_o),  32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    out_ready_i = 4'b1111;
    step();
    in_valid_i = 1'b1; in_sel_i = 4'b0001; in_data_i = 8'h5A;
    #1 chk("t6_ready", 32'(in_ready_o), 32'h1);
    chk("t6_lat0", 32'(out_valid_o), 32'h0);
    step();
    in_valid_i = 1'b0; in_sel_i = 4'b0000;
    chk("t6_valid", 32'(out_valid_o), 32'h1);
    chk("t6_data",  32'(ch_data(0)),  32'h5A);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/onehot_stream_demux.md
Name: onehot_stream_demux

Overview:
- Distributes one input valid/ready stream to one of NUM_CH output streams, selected per beat by a one-hot destination vector.
- It is the routing counterpart of the team's one-hot select muxes: a beat enters once and leaves on exactly one channel.
- Each output channel has a 1-entry registered holding stage, giving 1-cycle latency and full throughput per channel.
- A saturating drop counter and an optional one-hot checker provide debug visibility.

Parameters:
- NUM_CH, 4, number of output channels (2..16)
- DATA_W, 8, payload width in bits
- CNT_W, 8, width of the drop counter

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset_n  input  1  reset, asynchronous and active-low
- in_valid_i  input  1  input beat valid
- in_ready_o  output  1  input beat accepted when in_valid_i & in_ready_o
- in_data_i  input  DATA_W  input payload
- in_sel_i  input  NUM_CH  one-hot destination; bit k selects channel k
- out_valid_o  output  NUM_CH  per-channel valid
- out_ready_i  input  NUM_CH  per-channel ready
- out_data_o  output  NUM_CH*DATA_W  per-channel payload; channel k occupies bits [k*DATA_W +: DATA_W]
- drop_cnt_o  output  CNT_W  count of dropped beats, saturating
- err_o  output  1  sticky select error (see Optional Feature)
- err_clr_i  input  1  synchronous clear of err_o and drop_cnt_o

Behaviour:
- Reset (reset_n low, asynchronous): out_valid_o=0, out_data_o=0, drop_cnt_o=0, err_o=0. State is held while reset_n is low. Beats in flight are discarded. Release is synchronous to clk.
- Destination decode: channel d is the lowest set bit of in_sel_i (LSB priority). If in_sel_i==0, there is no destination.
- Per-channel slot k:
  - free_k = !out_valid_o[k] | out_ready_i[k].
  - Output side: when out_valid_o[k] & out_ready_i[k], the beat is consumed that cycle.
- in_ready_o:
  - equals free_d when a destination exists;
  - is 1 when in_sel_i==0 (beat is dropped);
  - is purely combinational from in_sel_i, out_valid_o and out_ready_i, and is independent of in_valid_i.
- Accept to channel d: on the next edge, out_valid_o[d]=1 and slot d data=in_data_i. Latency is 1 cycle from accept to out_valid_o.
- Simultaneous drain and accept on the same channel: the slot is reloaded with no bubble, so each channel sustains 1 beat/cycle.
- Drain with no accept: out_valid_o[k] clears on the next edge. out_data_o[k] holds its last value.
- A stalled channel (out_ready_i[k]=0, slot full) blocks only beats destined to k. Beats to other channels are accepted as soon as the head beat changes destination. There is no reordering within a channel.
- Drop: an accepted beat with in_sel_i==0 increments drop_cnt_o by 1, saturating at 2^CNT_W-1. No output asserts.
- err_clr_i, on the same edge:
  - clears err_o and drop_cnt_o;
  - overrides any increment or set in that cycle, so the result is 0.
- Out-of-range payload or select values do not matter: all widths are fixed, with no truncation or extension.

Optional Feature:
- Macro: ONEHOT_DEMUX_CHECK_EN.
- Defined:
  - an accepted beat with more than one bit set in in_sel_i is dropped (in_ready_o=1);
  - drop_cnt_o increments;
  - err_o sets and stays set until err_clr_i or reset;
  - a zero select is dropped and counted, but does not set err_o.
- Not defined:
  - multi-bit selects route to the lowest set bit, per the decode rule;
  - err_o is tied to 0;
  - err_clr_i still clears drop_cnt_o.

Test Plan:
- Reset, then send in_sel_i=4'b0100, data=8'hA5, with out_ready_i=4'b1111 -> next cycle out_valid_o=4'b0100 and ch2 data=8'hA5. It holds for exactly 1 cycle.
- Back-to-back beats 1..8 to channel 1, with out_ready_i[1] held at 1 -> in_ready_o stays 1 throughout. out_valid_o[1] is asserted for 8 consecutive cycles with data 1..8 in order.
- Channel 0 full with out_ready_i[0]=0 and a beat pending to ch0 -> in_ready_o=0. Change in_sel_i to 4'b1000 -> in_ready_o=1 and the beat lands on ch3. Ch0 keeps its old data.
- 300 beats with in_sel_i=0 -> no out_valid_o. drop_cnt_o saturates at 255. Pulse err_clr_i -> drop_cnt_o=0.
- in_sel_i=4'b0110, data=8'h3C:
  - with ONEHOT_DEMUX_CHECK_EN: dropped, err_o=1, drop_cnt_o=1;
  - without it: routed to ch1, err_o=0.
- Assert reset_n low mid-stream with ch2 valid, asynchronously between edges -> out_valid_o=0 and drop_cnt_o=0 immediately. After release, the first accepted beat has 1-cycle latency.
